// File: rtl/shf_arbiter.sv
// Two-port sequencer/arbiter that time-shares one external combinational
// LC-3b shifter and chains two passes to reach shift amounts of 16..31.
module shf_arbiter #(
  parameter bit INIT_PRIO = 1'b0,
  parameter bit CHAIN_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [1:0]  type0_i,
  input  logic [1:0]  type1_i,
  input  logic [4:0]  amt0_i,
  input  logic [4:0]  amt1_i,
  input  logic [15:0] a0_i,
  input  logic [15:0] a1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [15:0] result_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [5:0]  sh_ir6_o,
  output logic [15:0] sh_a_o,
  input  logic [15:0] sh_out_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_ILL = 2'b10;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [1:0]  type_q, type_d;
  logic        chain_q, chain_d;
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        busy_q, busy_d;
  logic [5:0]  sh_ir6_q, sh_ir6_d;
  logic [15:0] sh_a_q, sh_a_d;

  logic        gnt_valid_s;
  logic        gnt_port_s;
  logic [1:0]  sel_type_s;
  logic [4:0]  sel_amt_s;
  logic [15:0] sel_a_s;

  // Amount for the first pass: saturate at 15 when a second pass will follow.
  function automatic logic [3:0] first_amt(input logic [4:0] amt);
    if (CHAIN_EN && amt[4]) begin
      return 4'hF;
    end else begin
      return amt[3:0];
    end
  endfunction

  // Arbitration between the two request levels and operand selection.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_port_s  = 1'b0;
    if (req0_i && req1_i) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = prio_q;
    end else if (req0_i) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = 1'b0;
    end else if (req1_i) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_port_s  = 1'b0;
    end
    sel_type_s = gnt_port_s ? type1_i : type0_i;
    sel_amt_s  = gnt_port_s ? amt1_i  : amt0_i;
    sel_a_s    = gnt_port_s ? a1_i    : a0_i;
  end

  // Next-state and next-output logic; shifter drive is registered with the
  // state so it is stable for the whole pass cycle.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    type_d   = type_q;
    chain_d  = chain_q;
    result_d = result_q;
    err_d    = err_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    sh_ir6_d = 6'd0;
    sh_a_d   = 16'd0;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid_s) begin
          owner_d = gnt_port_s;
          prio_d  = ~gnt_port_s;
          type_d  = sel_type_s;
          chain_d = CHAIN_EN & sel_amt_s[4];
          ack0_d  = ~gnt_port_s;
          ack1_d  = gnt_port_s;
          if (sel_type_s == TYPE_ILL) begin
            state_d  = S_DONE;
            result_d = sel_a_s;
            err_d    = 1'b1;
            done0_d  = ~gnt_port_s;
            done1_d  = gnt_port_s;
          end else begin
            state_d  = S_PASS1;
            err_d    = 1'b0;
            sh_ir6_d = {sel_type_s, first_amt(sel_amt_s)};
            sh_a_d   = sel_a_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PASS1: begin
        if (chain_q) begin
          // sh_a_q doubles as the accumulator between the two passes.
          state_d  = S_PASS2;
          sh_ir6_d = {type_q, 4'd1};
          sh_a_d   = sh_out_i;
        end else begin
          state_d  = S_DONE;
          result_d = sh_out_i;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
        end
      end
      S_PASS2: begin
        state_d  = S_DONE;
        result_d = sh_out_i;
        done0_d  = ~owner_q;
        done1_d  = owner_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      prio_q   <= INIT_PRIO;
      owner_q  <= 1'b0;
      type_q   <= 2'b00;
      chain_q  <= 1'b0;
      result_q <= 16'd0;
      err_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      sh_ir6_q <= 6'd0;
      sh_a_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      type_q   <= type_d;
      chain_q  <= chain_d;
      result_q <= result_d;
      err_q    <= err_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      sh_ir6_q <= sh_ir6_d;
      sh_a_q   <= sh_a_d;
    end
  end

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign done0_o  = done0_q;
  assign done1_o  = done1_q;
  assign result_o = result_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;
  assign sh_ir6_o = sh_ir6_q;
  assign sh_a_o   = sh_a_q;

endmodule

// File: tb/tb_shf_arbiter.sv
// Bench for shf_arbiter: directed latency/arbitration/reset cases, then a
// randomized two-port run checked against an arithmetic shift model.
`timescale 1ns/1ps
module tb_shf_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_v;
  logic [1:0]  typ_v [2];
  logic [4:0]  amt_v [2];
  logic [15:0] a_v   [2];
  logic        ack0, ack1, done0, done1, err_o, busy_o;
  logic [15:0] result_o, sh_a, sh_out;
  logic [5:0]  sh_ir6;
  logic [1:0]  ack_w, done_w;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign ack_w  = {ack1, ack0};
  assign done_w = {done1, done0};

  shf_arbiter #(.INIT_PRIO(1'b0), .CHAIN_EN(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_i(req_v[0]), .req1_i(req_v[1]),
    .type0_i(typ_v[0]), .type1_i(typ_v[1]),
    .amt0_i(amt_v[0]), .amt1_i(amt_v[1]),
    .a0_i(a_v[0]), .a1_i(a_v[1]),
    .ack0_o(ack0), .ack1_o(ack1), .done0_o(done0), .done1_o(done1),
    .result_o(result_o), .err_o(err_o), .busy_o(busy_o),
    .sh_ir6_o(sh_ir6), .sh_a_o(sh_a), .sh_out_i(sh_out)
  );

  // Stand-in for the external LC-3b SHIFTER (IR[5:4]: 00 LSHF, 01 RSHFL, 11 RSHFA).
  always_comb begin
    case (sh_ir6[5:4])
      2'b00:   sh_out = sh_a << sh_ir6[3:0];
      2'b01:   sh_out = sh_a >> sh_ir6[3:0];
      2'b11:   sh_out = 16'($signed(sh_a) >>> sh_ir6[3:0]);
      default: sh_out = sh_a;
    endcase
  end

  // Full-range reference: one shift of 0..31 on a widened operand.
  function automatic logic [15:0] ref_shift(input logic [1:0] t, input int amt, input logic [15:0] a);
    logic [31:0] w;
    case (t)
      2'b00:   w = {16'h0000, a} << amt;
      2'b01:   w = {16'h0000, a} >> amt;
      2'b11:   w = 32'($signed({{16{a[15]}}, a}) >>> amt);
      default: w = {16'h0000, a};
    endcase
    return w[15:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check_eq("idle_timeout", busy_o, 0);
  endtask

  task automatic run_single(input int p, input logic [1:0] t, input logic [4:0] am,
                            input logic [15:0] av, input logic [15:0] exp_r, input string nm);
    logic [1:0] pm;
    pm = (p == 1) ? 2'b10 : 2'b01;
    wait_idle();
    typ_v[p] = t; amt_v[p] = am; a_v[p] = av; req_v[p] = 1'b1;
    @(negedge clk);
    check_eq({nm, "_ack"}, ack_w, pm);
    req_v[p] = 1'b0;
    if (t == 2'b10) begin
      check_eq({nm, "_done"}, done_w, pm);
      check_eq({nm, "_err"}, err_o, 1);
      check_eq({nm, "_result"}, result_o, exp_r);
      check_eq({nm, "_ir6"}, sh_ir6, 0);
      @(negedge clk);
      check_eq({nm, "_post"}, {ack_w, done_w}, 0);
    end else begin
      check_eq({nm, "_ir6_p1"}, sh_ir6, {t, (am[4] ? 4'hF : am[3:0])});
      check_eq({nm, "_sha_p1"}, sh_a, av);
      check_eq({nm, "_nodone1"}, done_w, 0);
      if (am[4]) begin
        @(negedge clk);
        check_eq({nm, "_ir6_p2"}, sh_ir6, {t, 4'd1});
        check_eq({nm, "_nodone2"}, done_w, 0);
      end
      @(negedge clk);
      check_eq({nm, "_done"}, done_w, pm);
      check_eq({nm, "_result"}, result_o, exp_r);
      check_eq({nm, "_err"}, err_o, 0);
      check_eq({nm, "_ir6_idle"}, sh_ir6, 0);
    end
  endtask

  task automatic new_op(input int p);
    int r;
    r = $urandom_range(0, 7);
    typ_v[p] = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b11 : 2'b10;
    amt_v[p] = 5'($urandom_range(0, 31));
    a_v[p]   = 16'($urandom);
    req_v[p] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_p[$], ack_c[$], dn_p[$];
    logic [15:0] dn_r[$];
    bit inflight, prio_m;
    int own, done_at, w;
    int wait_c [2];
    logic [15:0] own_res;
    logic own_err;

    rst_n = 1'b0; req_v = 2'b00;
    for (int i = 0; i < 2; i++) begin typ_v[i] = 2'b00; amt_v[i] = 5'd0; a_v[i] = 16'd0; end
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {ack_w, done_w, err_o, busy_o}, 0);
    check_eq("rst_data", {result_o, sh_a, sh_ir6}, 0);
    rst_n = 1'b1;

    run_single(0, 2'b00, 5'd1,  16'h0004, 16'h0008, "t1");
    run_single(1, 2'b01, 5'd1,  16'hFFFF, 16'h7FFF, "t2a");
    run_single(1, 2'b11, 5'd1,  16'hFFFE, 16'hFFFF, "t2b");
    run_single(0, 2'b11, 5'd20, 16'h8000, 16'hFFFF, "t4a");
    run_single(1, 2'b00, 5'd16, 16'hFFFF, 16'h0000, "t4b");
    run_single(0, 2'b10, 5'd3,  16'h1234, 16'h1234, "t5");
    run_single(1, 2'b01, 5'd0,  16'hBEEF, 16'hBEEF, "amt0");
    run_single(0, 2'b00, 5'd15, 16'h0003, 16'h8000, "amt15");
    run_single(1, 2'b01, 5'd31, 16'hFFFF, 16'h0000, "lsr31");
    run_single(0, 2'b11, 5'd31, 16'h7FFF, 16'h0000, "asr31");

    // Reset in the middle of the second pass of a chained shift.
    wait_idle();
    typ_v[0] = 2'b11; amt_v[0] = 5'd20; a_v[0] = 16'h8000; req_v[0] = 1'b1;
    @(negedge clk);
    check_eq("t6_ack", ack_w, 2'b01);
    req_v[0] = 1'b0;
    @(negedge clk);
    check_eq("t6_ir6_p2", sh_ir6, 6'h31);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outs", {ack_w, done_w, err_o, busy_o}, 0);
    check_eq("t6_rst_data", {result_o, sh_a, sh_ir6}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t6_no_done", {done_w, busy_o}, 0);
    end

    // Both ports held: alternating grants starting from port 0.
    typ_v[0] = 2'b00; amt_v[0] = 5'd3; a_v[0] = 16'h0011;
    typ_v[1] = 2'b01; amt_v[1] = 5'd2; a_v[1] = 16'h8000;
    req_v = 2'b11;
    for (int c = 1; c <= 30 && dn_p.size() < 4; c++) begin
      @(negedge clk);
      if (ack_w[0]) begin ack_p.push_back(0); ack_c.push_back(c); end
      if (ack_w[1]) begin ack_p.push_back(1); ack_c.push_back(c); end
      if (ack_p.size() >= 4) req_v = 2'b00;
      if (done_w[0]) begin dn_p.push_back(0); dn_r.push_back(result_o); end
      if (done_w[1]) begin dn_p.push_back(1); dn_r.push_back(result_o); end
    end
    req_v = 2'b00;
    check_eq("t3_nacks", ack_p.size(), 4);
    check_eq("t3_ndones", dn_p.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_p.size()) check_eq("t3_ack_port", ack_p[i], i % 2);
      if (i > 0 && i < ack_c.size()) check_eq("t3_ack_gap", ack_c[i] - ack_c[i-1], 3);
      if (i < dn_p.size()) begin
        check_eq("t3_done_port", dn_p[i], i % 2);
        check_eq("t3_result", dn_r[i], (i % 2 == 1) ? 16'h2000 : 16'h0088);
      end
    end

    // Randomized two-port run against the reference model.
    wait_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prio_m = 1'b0; inflight = 1'b0; own = 0; done_at = 0;
    own_res = 16'd0; own_err = 1'b0;
    wait_c[0] = 0; wait_c[1] = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      if (ack_w != 2'b00) begin
        w = (req_v == 2'b11) ? int'(prio_m) : (req_v[1] ? 1 : 0);
        check_eq("rnd_ack_port", ack_w, (req_v == 2'b00) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01));
        check_eq("rnd_ack_idle", inflight, 0);
        prio_m   = (w == 0);
        own      = w;
        own_res  = ref_shift(typ_v[w], int'(amt_v[w]), a_v[w]);
        own_err  = (typ_v[w] == 2'b10);
        done_at  = cyc + (own_err ? 0 : (amt_v[w] >= 5'd16) ? 2 : 1);
        inflight = 1'b1;
        wait_c[w] = 0;
        if (cyc < 400 && $urandom_range(0, 1) == 1) new_op(w);
        else req_v[w] = 1'b0;
      end
      if (done_w != 2'b00) begin
        check_eq("rnd_done_port", done_w, inflight ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00);
        check_eq("rnd_done_lat", cyc, done_at);
        check_eq("rnd_result", result_o, own_res);
        check_eq("rnd_err", err_o, own_err);
        inflight = 1'b0;
      end else if (inflight && cyc > done_at) begin
        check_eq("rnd_done_timeout", done_w, (own == 1) ? 2'b10 : 2'b01);
        inflight = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (req_v[p] && !ack_w[p]) begin
          wait_c[p]++;
          if (wait_c[p] > 12) begin
            check_eq("rnd_starve", ack_w[p], 1);
            wait_c[p] = 0;
          end
        end else if (!req_v[p] && cyc < 400 && $urandom_range(0, 2) == 0) begin
          new_op(p);
          wait_c[p] = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shf_arbiter.md
Name: shf_arbiter

Overview:
- Sequencer and arbiter that shares the single combinational LC-3b SHIFTER between two requesters: port 0 is the datapath SHF execution path, port 1 is the byte-lane alignment path.
- Accepts a request (type, amount, operand), drives the shifter's IR6/A inputs for one or two passes, registers the result and returns a done pulse.
- Extends the amount range to 0..31 by chaining passes.
- Sits beside the shifter in the execute stage; the shifter instance stays outside this block.

Parameters:
- INIT_PRIO, 0: requester that wins the first simultaneous contention after reset.
- CHAIN_EN, 1: when 0, AMT bit 4 is ignored and every operation is single-pass.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REQ0 / REQ1  in  1  request level; the requester holds it, with operands stable, until it sees ACK.
- TYPE0 / TYPE1  in  2  shift type: 00 left, 01 logical right, 11 arithmetic right, 10 illegal.
- AMT0 / AMT1  in  5  shift amount, 0..31.
- A0 / A1  in  16  operand.
- ACK0 / ACK1  out  1  one-cycle pulse: operands have been captured.
- DONE0 / DONE1  out  1  one-cycle pulse: RESULT and ERR are valid.
- RESULT  out  16  registered result, shared by both requesters.
- ERR  out  1  illegal type; valid with DONE.
- BUSY  out  1  high whenever state is not IDLE.
- SH_IR6  out  6  to SHIFTER IR6, {type, amount[3:0]}.
- SH_A  out  16  to SHIFTER A.
- SH_OUT  in  16  from SHIFTER OUT.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE, prio=INIT_PRIO.
  - ACK*, DONE*, RESULT, ERR, BUSY, SH_IR6 and SH_A all 0; internal operand registers cleared.
  - Reset asserted mid-operation abandons the operation; no DONE follows release.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - Samples REQ0/REQ1 on each edge.
  - Both high: grant goes to prio, then prio flips to the other port.
  - One high: that port is granted; prio flips away from the granted port.
  - Grant edge: capture TYPE, AMT and A of the granted port plus the owner id; the owner's ACK is set for exactly the next cycle.
  - Next state: TYPE=10 goes to DONE with RESULT<=A, ERR<=1. Otherwise goes to PASS1 with ERR<=0.
  - No request: stay IDLE, outputs 0.
- PASS1:
  - SH_A = captured A.
  - SH_IR6 = {type, amt1}, where amt1 = 15 if (CHAIN_EN and AMT>=16), else AMT[3:0].
  - At the edge: if a chain is needed, acc<=SH_OUT and go to PASS2. Otherwise RESULT<=SH_OUT and go to DONE.
- PASS2:
  - SH_A = acc, SH_IR6 = {type, 4'd1}. A total of 16 is equivalent to any shift of 16 or more for a 16-bit operand.
  - At the edge: RESULT<=SH_OUT, go to DONE.
- DONE:
  - DONE of the owner is high for this single cycle; RESULT/ERR are valid.
  - Go to IDLE. REQ is not sampled in DONE.
  - RESULT holds its value until the next completion.
- SH_IR6 and SH_A are 0 in IDLE and DONE.
- Latency, counted from the grant edge (edge 0):
  - ACK is high in cycle 1.
  - DONE is in cycle 2 for single-pass, cycle 3 for chained, and cycle 1 for illegal type (ACK and DONE coincide).
- Throughput: one single-pass operation every 3 cycles.
- A requester still holding REQ when the block returns to IDLE is treated as issuing a new operation.
- AMT=0 gives RESULT=A. AMT=15 is single-pass. AMT 16..31 gives 0 for left and logical right, and sign fill for arithmetic right.
- Requests arriving while BUSY are not acknowledged; the requester keeps REQ high.

Test Plan:
1. REQ0, TYPE 00, A=0x0004, AMT=1 -> ACK0 in cycle 1, SH_IR6=0x01, DONE0 in cycle 2, RESULT=0x0008, ERR=0.
2. REQ1, TYPE 01, A=0xFFFF, AMT=1 -> RESULT=0x7FFF. Then TYPE 11, A=0xFFFE, AMT=1 -> RESULT=0xFFFF. Only ACK1/DONE1 pulse.
3. REQ0 and REQ1 both held high with INIT_PRIO=0 -> grant order 0,1,0,1 with ACKs 3 cycles apart. Each DONE goes to the matching port and RESULT matches that port's operands.
4. TYPE 11, A=0x8000, AMT=20 -> SH_IR6=0x3F in PASS1, then 0x31 in PASS2; DONE in cycle 3; RESULT=0xFFFF. Then TYPE 00, A=0xFFFF, AMT=16 -> RESULT=0x0000.
5. TYPE 10, A=0x1234 -> ACK and DONE both in cycle 1, ERR=1, RESULT=0x1234, SH_IR6 stays 0.
6. RESET_N pulled low during PASS2 of a chained operation -> all outputs 0 immediately. After release: state IDLE, no DONE, prio=INIT_PRIO.
